// File: rtl/sonar_pkg.sv
// Shared types and constants for the sonar ranging blocks.
package sonar_pkg;

   localparam int DIST_W = 16;
   localparam logic [DIST_W-1:0] DIST_TIMEOUT = 16'hFFFF;

   typedef enum logic [2:0] {
      IDLE,
      TRIG,
      WAIT_RISE,
      MEASURE,
      DONE
   } sonar_state_t;

   // Increment that sticks at all-ones instead of wrapping to zero.
   function automatic logic [DIST_W-1:0] sat_inc(input logic [DIST_W-1:0] v);
      return (&v) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/echo_sync.sv
// Brings an asynchronous pin into the clk domain (two flops), then a third
// stage gives the settled level with registered rise/fall strobes aligned to it.
module echo_sync (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic level_q, level_d;
   logic rise_q, rise_d;
   logic fall_q, fall_d;

   // Next values: shift the pin through the chain, flag a change between stages 2 and 3.
   always_comb begin
      meta_d  = async_in;
      sync_d  = meta_q;
      level_d = sync_q;
      rise_d  = sync_q & ~level_q;
      fall_d  = ~sync_q & level_q;
   end

   // Synchronizer and edge-detect registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q  <= 1'b0;
         sync_q  <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         meta_q  <= meta_d;
         sync_q  <= sync_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign level = level_q;
   assign rise  = rise_q;
   assign fall  = fall_q;

endmodule

// File: rtl/sonar_ranger.sv
// Ultrasonic sonar driver: fires the trigger pulse, then times the echo pulse
// in ticks of TICK_DIV clocks and reports the width with a one-cycle strobe.
module sonar_ranger
   import sonar_pkg::*;
#(
   parameter int TRIG_CYCLES   = 500,
   parameter int TICK_DIV      = 50,
   parameter int TIMEOUT_TICKS = 30000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              echo,
   output logic              trig,
   output logic              busy,
   output logic              valid,
   output logic [DIST_W-1:0] distance,
   output logic              timeout
);

   localparam int TW = $clog2(TRIG_CYCLES + 1);
   localparam int PW = $clog2(TICK_DIV);
   localparam logic [TW-1:0]     TRIG_LAST  = TW'(TRIG_CYCLES - 1);
   localparam logic [TW-1:0]     TRIG_ONE   = TW'(1);
   localparam logic [PW-1:0]     PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0]     PRESC_ONE  = PW'(1);
   localparam logic [DIST_W-1:0] TICK_LIMIT = DIST_W'(TIMEOUT_TICKS);

   sonar_state_t      state_q, state_d;
   logic [TW-1:0]     trig_cnt_q, trig_cnt_d;
   logic [PW-1:0]     presc_q, presc_d;
   logic [DIST_W-1:0] tick_q, tick_d;
   logic [DIST_W-1:0] distance_q, distance_d;
   logic              timeout_q, timeout_d;

   logic              echo_level, echo_rise, echo_fall;
   logic              presc_wrap;
   logic [PW-1:0]     presc_inc;
   logic [DIST_W-1:0] tick_inc;

   echo_sync u_echo_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (echo),
      .level    (echo_level),
      .rise     (echo_rise),
      .fall     (echo_fall)
   );

   // Prescaler/tick advance used by both timed states; a tick lands on prescaler wrap.
   always_comb begin
      presc_wrap = (presc_q == PRESC_LAST);
      presc_inc  = presc_wrap ? '0 : presc_q + PRESC_ONE;
      tick_inc   = presc_wrap ? sat_inc(tick_q) : tick_q;
   end

   // Next-state and counter/result updates; echo edges win over a coincident timeout.
   always_comb begin
      state_d    = state_q;
      trig_cnt_d = trig_cnt_q;
      presc_d    = presc_q;
      tick_d     = tick_q;
      distance_d = distance_q;
      timeout_d  = timeout_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = TRIG;
               trig_cnt_d = '0;
            end
         end
         TRIG: begin
            trig_cnt_d = trig_cnt_q + TRIG_ONE;
            if (trig_cnt_q == TRIG_LAST) begin
               state_d = WAIT_RISE;
               presc_d = '0;
               tick_d  = '0;
            end
         end
         WAIT_RISE: begin
            if (echo_rise) begin
               state_d = MEASURE;
               presc_d = '0;
               tick_d  = '0;
            end else begin
               presc_d = presc_inc;
               tick_d  = tick_inc;
               if (tick_inc == TICK_LIMIT) begin
                  state_d    = DONE;
                  distance_d = DIST_TIMEOUT;
                  timeout_d  = 1'b1;
               end
            end
         end
         MEASURE: begin
            presc_d = presc_inc;
            tick_d  = tick_inc;
            if (echo_fall) begin
               state_d    = DONE;
               distance_d = tick_inc;
               timeout_d  = 1'b0;
            end else if (echo_level && (tick_inc == TICK_LIMIT)) begin
               state_d    = DONE;
               distance_d = DIST_TIMEOUT;
               timeout_d  = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, counters and held result registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         trig_cnt_q <= '0;
         presc_q    <= '0;
         tick_q     <= '0;
         distance_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         trig_cnt_q <= trig_cnt_d;
         presc_q    <= presc_d;
         tick_q     <= tick_d;
         distance_q <= distance_d;
         timeout_q  <= timeout_d;
      end
   end

   assign trig     = (state_q == TRIG);
   assign busy     = (state_q != IDLE);
   assign valid    = (state_q == DONE);
   assign distance = distance_q;
   assign timeout  = timeout_q;

endmodule

// File: tb/tb_sonar_ranger.sv
// Directed plus randomized measurements of sonar_ranger against a pulse-width model.
module tb_sonar_ranger;

   localparam int TRIG_CYCLES   = 4;
   localparam int TICK_DIV      = 2;
   localparam int TIMEOUT_TICKS = 100;
   localparam int LIMIT_CYCLES  = TICK_DIV * TIMEOUT_TICKS;
   localparam int SYNC_DELAY    = 3;

   logic        clk;
   logic        reset;
   logic        start;
   logic        echo;
   logic        trig;
   logic        busy;
   logic        valid;
   logic [15:0] distance;
   logic        timeout;

   int tests;
   int fails;

   sonar_ranger #(
      .TRIG_CYCLES   (TRIG_CYCLES),
      .TICK_DIV      (TICK_DIV),
      .TIMEOUT_TICKS (TIMEOUT_TICKS)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .echo     (echo),
      .trig     (trig),
      .busy     (busy),
      .valid    (valid),
      .distance (distance),
      .timeout  (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One full measurement. d < 0: echo never rises. Otherwise echo rises d
   // cycles after trig falls and stays high w cycles. Expected result comes
   // from the pulse width: w cycles = w/TICK_DIV ticks, timeout beyond the limit.
   task automatic run_measure(input int d, input int w, input bit extra_start);
      int          n;
      int          lat;
      int          nv;
      bit          seen;
      bit          exp_to;
      logic [15:0] exp_dist;
      int          exp_lat;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("trig_latency", trig, 1);
      check("busy_in_trig", busy, 1);
      n = 1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (trig !== 1'b1) break;
         n++;
      end
      check("trig_width", n, TRIG_CYCLES);
      check("busy_after_trig", busy, 1);
      if (d < 0) begin
         exp_to   = 1'b1;
         exp_dist = 16'hFFFF;
         exp_lat  = LIMIT_CYCLES;
      end else begin
         for (int i = 0; i < d; i++) tick();
         echo = 1'b1;
         if (w <= LIMIT_CYCLES) begin
            exp_to   = 1'b0;
            exp_dist = 16'(w / TICK_DIV);
            exp_lat  = w + SYNC_DELAY + 1;
         end else begin
            exp_to   = 1'b1;
            exp_dist = 16'hFFFF;
            exp_lat  = SYNC_DELAY + 1 + LIMIT_CYCLES;
         end
      end
      seen = 1'b0;
      lat  = 0;
      for (int t = 1; t <= 600; t++) begin
         tick();
         if (valid === 1'b1) begin
            seen = 1'b1;
            lat  = t;
            break;
         end
         if (d >= 0 && t == w) echo = 1'b0;
         if (extra_start) start = (t == w / 2);
      end
      start = 1'b0;
      check("valid_seen", seen, 1);
      check("valid_latency", lat, exp_lat);
      check("timeout_flag", timeout, exp_to);
      check("distance", distance, exp_dist);
      $display("[TB] measure d=%0d w=%0d extra_start=%0b -> distance=%0h timeout=%0b latency=%0d",
               d, w, extra_start, distance, timeout, lat);
      echo = 1'b0;
      tick();
      check("valid_one_cycle", valid, 0);
      check("idle_after_done", busy, 0);
      nv = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (valid === 1'b1) nv++;
      end
      check("no_extra_valid", nv, 0);
      check("distance_held", distance, exp_dist);
   endtask

   initial begin
      int n;
      int nv;
      int nb;
      tests = 0;
      fails = 0;
      reset = 1'b1;
      start = 1'b0;
      echo  = 1'b0;
      #1;
      check("rst_trig", trig, 0);
      check("rst_busy", busy, 0);
      check("rst_valid", valid, 0);
      check("rst_distance", distance, 0);
      check("rst_timeout", timeout, 0);
      repeat (3) tick();
      reset = 1'b0;
      repeat (2) tick();

      // Directed: nominal pulse, no echo, long echo, width boundaries.
      run_measure(10, 40, 1'b0);
      run_measure(-1, 0, 1'b0);
      run_measure(5, 300, 1'b0);
      run_measure(8, LIMIT_CYCLES, 1'b0);
      run_measure(8, LIMIT_CYCLES + 1, 1'b0);
      run_measure(3, 1, 1'b0);

      // Reset in the middle of MEASURE clears everything at once.
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (trig === 1'b1 && n < 20) begin
         tick();
         n++;
      end
      echo = 1'b1;
      repeat (20) tick();
      #2 reset = 1'b1;
      #1;
      check("midrst_trig", trig, 0);
      check("midrst_busy", busy, 0);
      check("midrst_valid", valid, 0);
      check("midrst_distance", distance, 0);
      check("midrst_timeout", timeout, 0);
      @(negedge clk);
      reset = 1'b0;
      echo  = 1'b0;
      nv = 0;
      nb = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (valid === 1'b1) nv++;
         if (busy === 1'b1) nb++;
      end
      check("postrst_no_valid", nv, 0);
      check("postrst_no_busy", nb, 0);
      $display("[TB] reset mid-measure: valid_after=%0d busy_after=%0d", nv, nb);

      // Echo glitch while idle must not start anything.
      echo = 1'b1;
      repeat (2) tick();
      echo = 1'b0;
      nv = 0;
      nb = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (valid === 1'b1) nv++;
         if (busy === 1'b1) nb++;
      end
      check("glitch_no_valid", nv, 0);
      check("glitch_no_busy", nb, 0);
      $display("[TB] idle glitch: valid=%0d busy=%0d", nv, nb);

      // Second start during MEASURE is dropped.
      run_measure(12, 60, 1'b1);

      // Randomized pulses spanning both sides of the width limit.
      for (int r = 0; r < 8; r++) begin
         run_measure(int'($urandom_range(2, 60)), int'($urandom_range(1, 240)), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sonar_ranger.md
Name: sonar_ranger

Overview:
- Drives one ultrasonic sonar: emits the trigger pulse, then measures the returning echo pulse width in microsecond ticks.
- Produces the 16-bit width with a one-cycle valid strobe, for the downstream 16-bit arithmetic datapath to consume.
- Sits between the sonar connector pins and the sensor-block arithmetic/register logic.
- One instance per sonar.

Parameters:
- TRIG_CYCLES, 500: trigger high time in clk cycles (10 us at 50 MHz).
- TICK_DIV, 50: clk cycles per measurement tick (1 us at 50 MHz); must be >= 2.
- TIMEOUT_TICKS, 30000: maximum ticks waited, for the echo rise and for the echo width separately; must be < 16'hFFFF.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request for a measurement; ignored while busy.
- echo  input  1  raw sonar echo pin; asynchronous to clk.
- trig  output  1  sonar trigger pin.
- busy  output  1  high from the cycle after an accepted start until return to IDLE.
- valid  output  1  one-cycle strobe; distance and timeout are valid when it is high.
- distance  output  16  echo width in ticks; 16'hFFFF on timeout.
- timeout  output  1  set with valid when no echo, or echo too long.

Behaviour:
- Reset (async, active-high) forces all outputs to 0, including distance and timeout.
  - Also clears the FSM to IDLE, all counters to 0, and the synchronizer flops to 0.
  - Reset mid-measurement aborts with no valid pulse; trig drops in the same cycle.
- echo passes through a 2-FF synchronizer, then a third flop for edge detection.
  - A rise/fall is seen 3 clk after the pin edge.
  - Echo activity outside WAIT_RISE/MEASURE is ignored.
- FSM states: IDLE, TRIG, WAIT_RISE, MEASURE, DONE. All transitions are registered.
- IDLE
  - busy=0, trig=0.
  - start=1 -> TRIG, and the trigger counter loads 0.
- TRIG
  - trig=1 for exactly TRIG_CYCLES cycles, then -> WAIT_RISE.
  - The prescaler and tick counter clear on exit.
- WAIT_RISE
  - The prescaler counts 0..TICK_DIV-1; the tick counter increments on wrap.
  - Synced rising edge -> MEASURE; the prescaler and tick counter clear on the same edge.
  - Tick counter == TIMEOUT_TICKS -> DONE with timeout=1 and distance=16'hFFFF.
  - Rise and timeout in the same cycle: the rise wins.
- MEASURE
  - The tick counter increments once per TICK_DIV cycles.
  - The 16-bit counter saturates and never wraps.
  - Synced falling edge -> DONE with distance=tick count and timeout=0.
  - A partial tick is truncated.
  - Count reaches TIMEOUT_TICKS with echo still high -> DONE with timeout=1 and distance=16'hFFFF.
  - Fall and timeout in the same cycle: the fall wins.
- DONE
  - valid=1 for exactly one cycle, then -> IDLE.
  - distance and timeout hold their values until the next DONE.
- start handling
  - start while busy (TRIG..DONE) is dropped, not queued.
  - start in the IDLE cycle right after DONE is accepted.
- Latency
  - start -> trig high: 1 clk.
  - Pin falling edge -> valid: 3 clk (sync) + 1 clk (DONE).
- Counter widths
  - Trigger counter: $clog2(TRIG_CYCLES+1).
  - Prescaler: $clog2(TICK_DIV).
  - Tick counter: 16 bits, unsigned.

Decomposition:
- Package sonar_pkg holds:
  - the state enum type sonar_state_t (IDLE, TRIG, WAIT_RISE, MEASURE, DONE);
  - the constant DIST_W=16;
  - the constant DIST_TIMEOUT=16'hFFFF.
- Sub-module echo_sync
  - Ports: clk, reset, async_in; outputs level, rise, fall.
  - Contains the 2-FF synchronizer plus the edge-detect flop.
  - Reused by later sensor blocks.

Test Plan (TRIG_CYCLES=4, TICK_DIV=2, TIMEOUT_TICKS=100):
- Reset asserted mid-MEASURE -> trig=0, busy=0, valid=0, distance=0 the same cycle; after release, no valid until a new start.
- start pulse, echo idle -> trig high for exactly 4 cycles starting 1 clk after start; busy high throughout.
- start; echo rises 10 clk after trig falls, stays high 40 clk -> one valid pulse, distance=20, timeout=0, valid 4 clk after echo falls.
- start, echo never rises -> valid with timeout=1, distance=16'hFFFF about 200 clk after trig falls; next start accepted normally.
- start; echo rises and stays high 300 clk -> valid with timeout=1, distance=16'hFFFF once 100 ticks elapse, before echo falls.
- Second start pulse during MEASURE, and echo glitches while IDLE -> exactly one valid per accepted start; the glitch produces no valid and no state change.
